// File: rtl/pwr_switch_seq.sv
// pwr_switch_seq: per-domain power switch sequencer with a single shared ramp slot
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   pwr_req     - per-domain power-on request (level)
//   sw_ack      - per-domain switch-chain ack (rail up)
//   data_in     - per-domain data, domain i at [i*DW +: DW]
//   sw_en       - per-domain power switch enable
//   iso_en      - per-domain isolation clamp enable
//   pwr_good    - per-domain powered-and-released flag
//   err_timeout - per-domain ack-timeout flag (held while in FAULT)
//   data_out    - per-domain registered data, zero unless the domain is ON
module pwr_switch_seq #(
    parameter int N_DOM       = 4,
    parameter int DW          = 8,
    parameter int RAMP_CYC    = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_DOM-1:0]    pwr_req,
    input  logic [N_DOM-1:0]    sw_ack,
    input  logic [N_DOM*DW-1:0] data_in,
    output logic [N_DOM-1:0]    sw_en,
    output logic [N_DOM-1:0]    iso_en,
    output logic [N_DOM-1:0]    pwr_good,
    output logic [N_DOM-1:0]    err_timeout,
    output logic [N_DOM*DW-1:0] data_out
);
    localparam int CMAX = RAMP_CYC > ACK_TIMEOUT ? RAMP_CYC : ACK_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    typedef enum logic [2:0] {OFF, RAMP, WAIT_ACK, ON, ISO, FAULT} state_t;
    state_t         st  [N_DOM];
    logic [CW-1:0]  cnt [N_DOM];
    logic [DW-1:0]  dq  [N_DOM];
    logic             busy;
    logic [N_DOM-1:0] grant;
    // Slot occupancy comes from registered state, so a slot freed on an edge
    // is only grantable on the following edge.
    always_comb begin
        busy  = 1'b0;
        grant = '0;
        for (int i = 0; i < N_DOM; i++)
            busy = busy | (st[i] == RAMP) | (st[i] == WAIT_ACK);
        for (int i = 0; i < N_DOM; i++)
            if (!busy && grant == '0 && st[i] == OFF && pwr_req[i]) grant[i] = 1'b1;
    end
    for (genvar g = 0; g < N_DOM; g++) begin : g_dom
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st[g]  <= OFF;
                cnt[g] <= '0;
                dq[g]  <= '0;
            end else begin
                // Capture only while staying ON, so the ISO cycle already reads 0.
                dq[g] <= (st[g] == ON && pwr_req[g]) ? data_in[g*DW +: DW] : '0;
                case (st[g])
                    OFF: if (grant[g]) begin
                        st[g]  <= RAMP;
                        cnt[g] <= '0;
                    end
                    RAMP: if (!pwr_req[g]) st[g] <= OFF;
                    else if (cnt[g] == CW'(RAMP_CYC - 1)) begin
                        st[g]  <= WAIT_ACK;
                        cnt[g] <= '0;
                    end else cnt[g] <= cnt[g] + CW'(1);
                    // Ack is checked before the timeout so a last-cycle ack wins.
                    WAIT_ACK: if (!pwr_req[g]) st[g] <= OFF;
                    else if (sw_ack[g]) st[g] <= ON;
                    else if (cnt[g] == CW'(ACK_TIMEOUT - 1)) st[g] <= FAULT;
                    else cnt[g] <= cnt[g] + CW'(1);
                    ON:      if (!pwr_req[g]) st[g] <= ISO;
                    ISO:     st[g] <= OFF;
                    FAULT:   if (!pwr_req[g]) st[g] <= OFF;
                    default: st[g] <= OFF;
                endcase
            end
        end
        assign sw_en[g]              = st[g] == RAMP || st[g] == WAIT_ACK || st[g] == ON || st[g] == ISO;
        assign iso_en[g]             = st[g] != ON;
        assign pwr_good[g]           = st[g] == ON;
        assign err_timeout[g]        = st[g] == FAULT;
        assign data_out[g*DW +: DW]  = dq[g];
    end
endmodule

// File: tb/tb_pwr_switch_seq.sv
// tb_pwr_switch_seq: directed self-checking bench for pwr_switch_seq
module tb_pwr_switch_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pwr_req, sw_ack;
    logic [31:0] data_in;
    logic [3:0]  sw_en, iso_en, pwr_good, err_timeout;
    logic [31:0] data_out;
    int errors = 0;
    int checks = 0;

    pwr_switch_seq #(.N_DOM(4), .DW(8), .RAMP_CYC(4), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .sw_ack(sw_ack), .data_in(data_in),
        .sw_en(sw_en), .iso_en(iso_en), .pwr_good(pwr_good), .err_timeout(err_timeout),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; pwr_req = '0; sw_ack = '0; data_in = '0;
        repeat (2) step();
        chk("rst_sw_en", sw_en, 4'h0);
        chk("rst_iso_en", iso_en, 4'hF);
        chk("rst_pwr_good", pwr_good, 4'h0);
        chk("rst_err", err_timeout, 4'h0);
        chk("rst_data", data_out, 32'h0);
        // power-up of domain 0
        rst_n = 1'b1; pwr_req = 4'b0001; data_in = 32'h0000_00A5;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("up_ramp_sw", {pwr_good, sw_en}, 8'h01);
        end
        step();
        chk("up_wait_sw", {pwr_good, sw_en}, 8'h01);
        sw_ack = 4'b0001;
        step();
        chk("up_on_good", {pwr_good, iso_en}, 8'h1E);
        chk("up_on_data0", data_out, 32'h0);
        step();
        chk("up_on_data1", data_out, 32'h0000_00A5);
        // power-down of domain 0
        pwr_req = 4'b0000;
        step();
        chk("dn_iso", {sw_en, iso_en, pwr_good}, 12'h1F0);
        chk("dn_iso_data", data_out, 32'h0);
        step();
        chk("dn_off", {sw_en, iso_en}, 8'h0F);
        sw_ack = 4'b0000;
        // arbitration: domains 1 and 2 together
        pwr_req = 4'b0110;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("arb_d1_first", sw_en, 4'b0010);
        end
        sw_ack = 4'b0010;
        step();
        chk("arb_d1_on", {pwr_good, sw_en}, 8'h22);
        step();
        chk("arb_d2_ramp", sw_en, 4'b0110);
        pwr_req = 4'b0000; sw_ack = 4'b0000;
        step();
        chk("arb_drop", {sw_en, iso_en}, 8'h2F);
        step();
        chk("arb_off", sw_en, 4'h0);
        // timeout on domain 3 with domain 0 waiting
        pwr_req = 4'b1000;
        step();
        chk("to_grant", sw_en, 4'b1000);
        pwr_req = 4'b1001;
        for (int k = 2; k <= 12; k++) begin
            step();
            chk("to_pending", {err_timeout, sw_en}, 8'h08);
        end
        step();
        chk("to_fault", {err_timeout, sw_en}, 8'h80);
        pwr_req = 4'b0001;
        step();
        chk("to_clear", {err_timeout, sw_en}, 8'h01);
        pwr_req = 4'b0000;
        step();
        chk("to_abort_d0", sw_en, 4'h0);
        // ack in the last WAIT_ACK cycle beats the timeout
        pwr_req = 4'b1000;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("last_pending", {err_timeout, pwr_good}, 8'h00);
        end
        sw_ack = 4'b1000;
        step();
        chk("last_ack_wins", {err_timeout, pwr_good}, 8'h08);
        pwr_req = 4'b0000; sw_ack = 4'b0000;
        step();
        chk("last_iso", {sw_en, iso_en}, 8'h8F);
        step();
        chk("last_off", sw_en, 4'h0);
        // abort of domain 1 in its second RAMP cycle
        pwr_req = 4'b0010;
        step();
        step();
        chk("ab_ramp2", sw_en, 4'b0010);
        pwr_req = 4'b0100;
        step();
        chk("ab_off", sw_en, 4'h0);
        step();
        chk("ab_slot_free", sw_en, 4'b0100);
        pwr_req = 4'b0000;
        step();
        // reset during WAIT_ACK
        pwr_req = 4'b0001;
        step();
        repeat (4) step();
        chk("rr_wait", sw_en, 4'b0001);
        rst_n = 1'b0;
        #2;
        chk("rr_async", {sw_en, iso_en, pwr_good, err_timeout}, 16'h0F00);
        chk("rr_data", data_out, 32'h0);
        step();
        chk("rr_held", sw_en, 4'h0);
        rst_n = 1'b1; sw_ack = 4'b0001;
        step();
        chk("rr_regrant", sw_en, 4'b0001);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("rr_full_ramp", pwr_good, 4'h0);
        end
        step();
        chk("rr_on", pwr_good, 4'b0001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
